hw_nios_onchip_mem_arbiter: RTL and testbench
=============================================

Name: hw_nios_onchip_mem_arbiter

Overview:
Two-port Avalon-MM arbiter that shares the single-port 1024x32 on-chip RAM (byte-enabled, registered address, unregistered q) between two requesters, e.g. the Nios data master and a DMA/debug master.
Round-robin with a bounded hold window: an owner keeps back-to-back access for up to MAX_BURST cycles before it must yield to a contending requester.
Pipelines read-data-valid and routes it back to the issuing port.
Sits between the interconnect masters and the memory slave port.

Parameters:
ADDR_W, 10, word address width (1024 words).
DATA_W, 32, data width.
BE_W, 4, byteenable width (DATA_W/8).
MAX_BURST, 4, max consecutive grants to one owner while the other requests; legal range 1..15.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_address  in  ADDR_W  port 0 word address
m0_byteenable  in  BE_W  port 0 byte lanes
m0_read  in  1  port 0 read request
m0_write  in  1  port 0 write request
m0_writedata  in  DATA_W  port 0 write data
m0_waitrequest  out  1  high = port 0 request not accepted this cycle
m0_readdata  out  DATA_W  port 0 read data
m0_readdatavalid  out  1  port 0 read data valid
m1_* (address, byteenable, read, write, writedata, waitrequest, readdata, readdatavalid): same as m0_*, for port 1
mem_address  out  ADDR_W  to RAM
mem_byteenable  out  BE_W  to RAM
mem_chipselect  out  1  to RAM
mem_write  out  1  to RAM
mem_writedata  out  DATA_W  to RAM
mem_clken  out  1  RAM clock enable; tied 1
mem_readdata  in  DATA_W  RAM q, valid 1 cycle after read address is presented

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high.
- Request: reqN = mN_read | mN_write. Asserting both read and write on one port is illegal; the bench asserts it never occurs.
- State: st in {IDLE, OWN0, OWN1}; hold_cnt (4 bits); last_grant (1 bit).
- Reset values: st=IDLE, hold_cnt=0, last_grant=1 (port 0 wins first tie), rd_pend=0, rd_tag=0.
- Outputs while reset is high: both waitrequest=1, mem_chipselect=0, mem_write=0, both readdatavalid=0.
- Grant is combinational, decided in the same cycle as the request:
  - IDLE, one requester: grant it. Both: grant ~last_grant.
  - OWNx: grant x if reqx and (!reqy or hold_cnt < MAX_BURST-1). Otherwise grant y if reqy. Otherwise no grant.
- Granted port: waitrequest=0. Its address, byteenable and writedata drive mem_*; mem_chipselect=1; mem_write=mX_write.
- Non-granted ports: waitrequest=1 whenever they request.
- Idle memory outputs: when nothing is granted, mem_chipselect=0, mem_write=0, and mem_address/byteenable/writedata hold the port-0 values.
- State update on the clk edge:
  - Grant x: st=OWNx and last_grant=x. hold_cnt=hold_cnt+1 (saturating at 15) if x was already owner, else 0.
  - No grant: st=IDLE, hold_cnt=0.
- Read pipeline: on a granted read, rd_pend<=1 and rd_tag<=x; otherwise rd_pend<=0.
  - mX_readdatavalid = rd_pend & (rd_tag==X).
  - mem_readdata is broadcast on both mX_readdata.
  - Read latency is exactly 1 cycle after acceptance.
  - Back-to-back reads from alternating ports each return in order, one per cycle.
- Writes produce no readdatavalid. A write followed by a read to the same address on the next cycle returns the new data; the RAM commits writes at the edge.
- Throughput: one access per cycle, no bubbles on grant switch.
- Reset mid-read: any pending readdatavalid is dropped. The requester re-issues after reset.
- MAX_BURST=1: strict alternation under continuous contention.

Decomposition:
- Shared package hw_nios_arb_pkg: state enum (IDLE/OWN0/OWN1), ADDR_W/DATA_W/BE_W constants, port-index type.
- One natural sub-module: hw_nios_rr_grant. It holds the combinational grant logic plus the st, hold_cnt and last_grant registers, and outputs a one-hot grant.
- Muxing and the read-tag pipeline stay in the top level.

Test Plan:
- Single port: m0 write 0xDEADBEEF to addr 0x010 (be=4'hF), then read 0x010 -> m0_waitrequest=0 on both cycles; m0_readdatavalid exactly 1 cycle after the read with data 0xDEADBEEF; m1_readdatavalid stays 0.
- Byte lanes: write 0x11223344 to 0x3FF, then write 0xAA000000 with be=4'b1000, then read -> 0xAA223344 (wrap-top address).
- Tie from reset: m0 and m1 both read on the first cycle after reset -> m0 granted first, m1 next cycle; each readdatavalid is tagged to the correct port in order.
- Hold window: MAX_BURST=4, m0 and m1 both requesting continuously -> grant sequence 0,0,0,0,1,1,1,1,0...; the losing port's waitrequest stays high until its turn.
- Idle/owner drop: m1 owns, drops request, m0 requests -> m0 granted that same cycle with no bubble; with no requests -> mem_chipselect=0 and st returns to IDLE.
- Reset mid-operation: assert reset on the cycle after a granted m1 read -> m1_readdatavalid stays 0; the next m0/m1 tie grants m0.

Source files
------------

// File: rtl/hw_nios_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hw_nios_arb_pkg
// Brief    : Shared types and constants for the on-chip memory arbiter.
// Revision : 1.0
// ============================================================================
package hw_nios_arb_pkg;

    localparam int ARB_ADDR_W = 10;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_BE_W   = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    typedef logic port_idx_t;

endpackage
`default_nettype wire

// File: rtl/hw_nios_rr_grant.sv
`default_nettype none
// ============================================================================
// Module   : hw_nios_rr_grant
// Brief    : Round-robin grant with bounded hold window; one-hot grant output.
// Revision : 1.0
// ============================================================================
module hw_nios_rr_grant
    import hw_nios_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req0,
    input  logic       i_req1,
    output logic [1:0] o_grant
);

    localparam logic [3:0] C_HOLD_LIMIT = 4'(MAX_BURST - 1);

    arb_state_t r_st;
    arb_state_t w_st_nxt;
    logic [3:0] r_hold_cnt;
    logic [3:0] w_hold_nxt;
    logic [3:0] w_hold_inc;
    logic       r_last_grant;
    logic       w_last_nxt;
    logic [1:0] w_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st         <= ST_IDLE;
            r_hold_cnt   <= 4'd0;
            r_last_grant <= 1'b1;
        end else begin
            r_st         <= w_st_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_last_grant <= w_last_nxt;
        end
    end

    assign w_hold_inc = (r_hold_cnt == 4'hF) ? 4'hF : r_hold_cnt + 4'd1;

    always_comb begin
        w_grant    = 2'b00;
        w_st_nxt   = ST_IDLE;
        w_hold_nxt = 4'd0;
        w_last_nxt = r_last_grant;

        case (r_st)
            ST_OWN0: begin
                if (i_req0 && (!i_req1 || (r_hold_cnt < C_HOLD_LIMIT)))
                    w_grant = 2'b01;
                else if (i_req1)
                    w_grant = 2'b10;
            end
            ST_OWN1: begin
                if (i_req1 && (!i_req0 || (r_hold_cnt < C_HOLD_LIMIT)))
                    w_grant = 2'b10;
                else if (i_req0)
                    w_grant = 2'b01;
            end
            default: begin
                // Ties go to the port that did not win last time.
                if (i_req0 && i_req1)
                    w_grant = r_last_grant ? 2'b01 : 2'b10;
                else
                    w_grant = {i_req1, i_req0};
            end
        endcase

        if (w_grant[0]) begin
            w_st_nxt   = ST_OWN0;
            w_last_nxt = 1'b0;
            w_hold_nxt = (r_st == ST_OWN0) ? w_hold_inc : 4'd0;
        end else if (w_grant[1]) begin
            w_st_nxt   = ST_OWN1;
            w_last_nxt = 1'b1;
            w_hold_nxt = (r_st == ST_OWN1) ? w_hold_inc : 4'd0;
        end
    end

    assign o_grant = rst ? 2'b00 : w_grant;

endmodule
`default_nettype wire

// File: rtl/hw_nios_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hw_nios_onchip_mem_arbiter
// Brief    : Two-port Avalon-MM arbiter in front of a single-port on-chip RAM.
// Revision : 1.0
// ============================================================================
module hw_nios_onchip_mem_arbiter
    import hw_nios_arb_pkg::*;
#(
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int DATA_W    = ARB_DATA_W,
    parameter int BE_W      = ARB_BE_W,
    parameter int MAX_BURST = 4
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic [1:0] w_grant;
    logic       w_rd_accept;
    logic       r_rd_pend;
    port_idx_t  r_rd_tag;

    hw_nios_rr_grant #(
        .MAX_BURST (MAX_BURST)
    ) u_grant (
        .clk     (clk),
        .rst     (reset),
        .i_req0  (m0_read | m0_write),
        .i_req1  (m1_read | m1_write),
        .o_grant (w_grant)
    );

    // Port 1 steers the memory bus only when granted; otherwise port 0 values sit on it.
    assign mem_address    = w_grant[1] ? m1_address    : m0_address;
    assign mem_byteenable = w_grant[1] ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = w_grant[1] ? m1_writedata  : m0_writedata;
    assign mem_chipselect = |w_grant;
    assign mem_write      = (w_grant[0] & m0_write) | (w_grant[1] & m1_write);
    assign mem_clken      = 1'b1;

    assign m0_waitrequest = ~w_grant[0];
    assign m1_waitrequest = ~w_grant[1];

    assign w_rd_accept = (w_grant[0] & m0_read) | (w_grant[1] & m1_read);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pend <= 1'b0;
            r_rd_tag  <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_accept;
            if (w_rd_accept)
                r_rd_tag <= w_grant[1];
        end
    end

    // Gated by reset so a read in flight when reset arrives is dropped immediately.
    assign m0_readdatavalid = r_rd_pend & ~r_rd_tag & ~reset;
    assign m1_readdatavalid = r_rd_pend &  r_rd_tag & ~reset;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule
`default_nettype wire

// File: tb/tb_hw_nios_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hw_nios_onchip_mem_arbiter
// Brief    : Directed self-checking bench with a byte-enabled RAM model.
// Revision : 1.0
// ============================================================================
module tb_hw_nios_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hw_nios_onchip_mem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    // RAM: registered address, unregistered q, writes commit at the edge.
    logic [31:0] ram [0:1023];
    logic [9:0]  ram_addr_q;

    always @(posedge clk) begin
        if (mem_clken) begin
            ram_addr_q <= mem_address;
            if (mem_chipselect && mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b])
                        ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    always @(negedge clk)
        if (!reset)
            assert (!(m0_read && m0_write) && !(m1_read && m1_write))
            else $error("FAIL illegal_rw both read and write asserted on one port");

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic all_idle();
        m0_read = 1'b0; m0_write = 1'b0;
        m1_read = 1'b0; m1_write = 1'b0;
    endtask

    task automatic m0_rd(input logic [9:0] a);
        m0_read = 1'b1; m0_write = 1'b0; m0_address = a; m0_byteenable = 4'hF;
    endtask

    task automatic m1_rd(input logic [9:0] a);
        m1_read = 1'b1; m1_write = 1'b0; m1_address = a; m1_byteenable = 4'hF;
    endtask

    task automatic m0_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        m0_read = 1'b0; m0_write = 1'b1; m0_address = a; m0_writedata = d; m0_byteenable = be;
    endtask

    task automatic m1_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        m1_read = 1'b0; m1_write = 1'b1; m1_address = a; m1_writedata = d; m1_byteenable = be;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int exp_seq [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

    initial begin
        reset = 1'b1;
        m0_address = '0; m1_address = '0;
        m0_byteenable = '0; m1_byteenable = '0;
        m0_writedata = '0; m1_writedata = '0;
        all_idle();

        // Reset: requests present but must be held off.
        next_cycle();
        m0_read = 1'b1; m1_write = 1'b1;
        settle();
        chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
        chk("rst_cs", 32'(mem_chipselect), 32'd0);
        chk("rst_memwr", 32'(mem_write), 32'd0);
        chk("rst_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
        chk("clken", 32'(mem_clken), 32'd1);
        next_cycle();
        all_idle();
        reset = 1'b0;

        // Single port write then read.
        next_cycle();
        m0_wr(10'h010, 32'hDEADBEEF, 4'hF);
        settle();
        chk("wr_m0_wait", 32'(m0_waitrequest), 32'd0);
        chk("wr_cs", 32'(mem_chipselect), 32'd1);
        chk("wr_memwr", 32'(mem_write), 32'd1);
        chk("wr_addr", 32'(mem_address), 32'h010);
        next_cycle();
        m0_rd(10'h010);
        settle();
        chk("rd_m0_wait", 32'(m0_waitrequest), 32'd0);
        chk("rd_memwr", 32'(mem_write), 32'd0);
        chk("wr_no_rdv", 32'(m0_readdatavalid), 32'd0);
        next_cycle();
        all_idle();
        settle();
        chk("rd_m0_rdv", 32'(m0_readdatavalid), 32'd1);
        chk("rd_m0_data", m0_readdata, 32'hDEADBEEF);
        chk("rd_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        chk("idle_cs", 32'(mem_chipselect), 32'd0);
        next_cycle();
        settle();
        chk("rd_rdv_once", 32'(m0_readdatavalid), 32'd0);

        // Byte lanes at the top address.
        m0_wr(10'h3FF, 32'h11223344, 4'hF);
        next_cycle();
        m0_wr(10'h3FF, 32'hAA000000, 4'b1000);
        next_cycle();
        m0_rd(10'h3FF);
        next_cycle();
        all_idle();
        settle();
        chk("be_rdv", 32'(m0_readdatavalid), 32'd1);
        chk("be_data", m0_readdata, 32'hAA223344);

        // Tie right after reset: port 0 first.
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        m0_rd(10'h010);
        m1_rd(10'h3FF);
        settle();
        chk("tie_m0_wait", 32'(m0_waitrequest), 32'd0);
        chk("tie_m1_wait", 32'(m1_waitrequest), 32'd1);
        next_cycle();
        m0_read = 1'b0;
        settle();
        chk("tie2_m1_wait", 32'(m1_waitrequest), 32'd0);
        chk("tie2_m0_rdv", 32'(m0_readdatavalid), 32'd1);
        chk("tie2_m0_data", m0_readdata, 32'hDEADBEEF);
        chk("tie2_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        next_cycle();
        all_idle();
        settle();
        chk("tie3_m1_rdv", 32'(m1_readdatavalid), 32'd1);
        chk("tie3_m1_data", m1_readdata, 32'hAA223344);
        chk("tie3_m0_rdv", 32'(m0_readdatavalid), 32'd0);

        // Hold window under continuous contention.
        next_cycle();
        m0_rd(10'h010);
        m1_rd(10'h3FF);
        for (int k = 0; k < 10; k++) begin
            settle();
            chk($sformatf("hold_m0_wait_%0d", k), 32'(m0_waitrequest), 32'(exp_seq[k] != 0));
            chk($sformatf("hold_m1_wait_%0d", k), 32'(m1_waitrequest), 32'(exp_seq[k] == 0));
            if (k > 0)
                chk($sformatf("hold_m1_rdv_%0d", k), 32'(m1_readdatavalid), 32'(exp_seq[k-1] != 0));
            next_cycle();
        end
        all_idle();
        settle();
        chk("hold_last_m0_rdv", 32'(m0_readdatavalid), 32'd1);

        // Owner drop: port 1 owns, then port 0 takes over with no bubble.
        next_cycle();
        m1_wr(10'h020, 32'h00000055, 4'hF);
        settle();
        chk("own1_m1_wait", 32'(m1_waitrequest), 32'd0);
        next_cycle();
        all_idle();
        m0_rd(10'h3FF);
        settle();
        chk("drop_m0_wait", 32'(m0_waitrequest), 32'd0);
        chk("drop_cs", 32'(mem_chipselect), 32'd1);
        chk("drop_addr", 32'(mem_address), 32'h3FF);
        next_cycle();
        all_idle();
        settle();
        chk("drop_idle_cs", 32'(mem_chipselect), 32'd0);
        chk("drop_idle_wait", {30'd0, m1_waitrequest, m0_waitrequest}, 32'd3);
        chk("drop_m0_data", m0_readdata, 32'hAA223344);
        // Back in IDLE with last grant port 0, so a tie goes to port 1.
        next_cycle();
        m0_rd(10'h010);
        m1_rd(10'h020);
        settle();
        chk("idle_tie_m1_wait", 32'(m1_waitrequest), 32'd0);
        chk("idle_tie_m0_wait", 32'(m0_waitrequest), 32'd1);
        next_cycle();
        m1_read = 1'b0;
        settle();
        chk("idle_tie_m1_data", m1_readdata, 32'h00000055);
        chk("idle_tie_m1_rdv", 32'(m1_readdatavalid), 32'd1);
        next_cycle();
        all_idle();

        // Reset on the cycle after an accepted port 1 read.
        next_cycle();
        m1_rd(10'h020);
        settle();
        chk("rmid_m1_wait", 32'(m1_waitrequest), 32'd0);
        next_cycle();
        all_idle();
        reset = 1'b1;
        settle();
        chk("rmid_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        chk("rmid_m0_rdv", 32'(m0_readdatavalid), 32'd0);
        next_cycle();
        reset = 1'b0;
        m0_rd(10'h010);
        m1_rd(10'h020);
        settle();
        chk("rpost_m0_wait", 32'(m0_waitrequest), 32'd0);
        chk("rpost_m1_wait", 32'(m1_waitrequest), 32'd1);
        chk("rpost_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        next_cycle();
        m0_read = 1'b0;
        settle();
        chk("rpost_m0_rdv", 32'(m0_readdatavalid), 32'd1);
        chk("rpost_m1_wait2", 32'(m1_waitrequest), 32'd0);
        next_cycle();
        all_idle();
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
